// File: rtl/ram_sdp_rw_if.sv
// Bus bundle between the RAM test sequencer and the simple dual-port RAM core.
// The sequencer drives the master side and the RAM core implements the slave side.
interface ram_sdp_rw_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 6
) ();

  logic                  rw_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;

  modport master (
    output rw_en,
    output wr_addr,
    output wr_data,
    output rd_addr,
    input  rd_data,
    input  rd_valid
  );

  modport slave (
    input  rw_en,
    input  wr_addr,
    input  wr_data,
    input  rd_addr,
    output rd_data,
    output rd_valid
  );

endinterface

// File: rtl/ram_sdp_rw_core.sv
// 64x8 simple dual-port RAM: rw_en selects a write or a registered read each cycle.
// Define RAM_OUT_REG_EN to add an output pipeline stage (2-cycle read latency).
module ram_sdp_rw_core #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DEPTH      = 64
) (
  input logic             sys_clk,
  input logic             rst_n,
  ram_sdp_rw_if.slave     bus
);

  // Storage is never reset; it only starts out zeroed.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH] = '{default: '0};

  logic                  mem_wr_en;
  logic [ADDR_WIDTH-1:0] mem_wr_addr;
  logic [DATA_WIDTH-1:0] mem_wr_data;

  logic [DATA_WIDTH-1:0] rd_data_d, rd_data_q;
  logic                  rd_valid_d, rd_valid_q;

  always_comb begin
    mem_wr_en   = bus.rw_en;
    mem_wr_addr = bus.wr_addr;
    mem_wr_data = bus.wr_data;
  end

  always_ff @(posedge sys_clk) begin
    if (mem_wr_en) begin
      mem_q[mem_wr_addr] <= mem_wr_data;
    end
  end

  // Read stage: load on read cycles, hold data and drop valid on write cycles.
  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    if (!bus.rw_en) begin
      rd_data_d  = mem_q[bus.rd_addr];
      rd_valid_d = 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

`ifdef RAM_OUT_REG_EN
  logic [DATA_WIDTH-1:0] out_data_d, out_data_q;
  logic                  out_valid_d, out_valid_q;

  // Output stage only captures a valid read result, so a pending result drains
  // through a write cycle and the held value is otherwise kept.
  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = rd_valid_q;
    if (rd_valid_q) begin
      out_data_d = rd_data_q;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.rd_data  = out_data_q;
  assign bus.rd_valid = out_valid_q;
`else
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
`endif

endmodule

// File: tb/tb_ram_sdp_rw_core.sv
// Directed self-checking bench for ram_sdp_rw_core; read latency follows RAM_OUT_REG_EN.
module tb_ram_sdp_rw_core;

`ifdef RAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic sys_clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  ram_sdp_rw_if #(.DATA_WIDTH(8), .ADDR_WIDTH(6)) bus ();

  ram_sdp_rw_core #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(6),
    .DEPTH     (64)
  ) dut (
    .sys_clk(sys_clk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_write(input logic [5:0] a, input logic [7:0] d);
    bus.rw_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    tick();
  endtask

  // Hold the read address for LAT edges so the result is on the output.
  task automatic do_read(input logic [5:0] a, output logic [7:0] d, output logic v);
    bus.rw_en   = 1'b0;
    bus.rd_addr = a;
    repeat (LAT) tick();
    d = bus.rd_data;
    v = bus.rd_valid;
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    bus.rw_en   = 1'b1;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.rd_addr = '0;
    #3;
    n_checks++;
    if (bus.rd_data !== 8'h00 || bus.rd_valid !== 1'b0)
      $display("FAIL reset_early: got data=%h valid=%b, want 00/0", bus.rd_data, bus.rd_valid);
    else n_pass++;
    #10;
    n_checks++;
    if (bus.rd_data !== 8'h00 || bus.rd_valid !== 1'b0)
      $display("FAIL reset_hold: got data=%h valid=%b, want 00/0", bus.rd_data, bus.rd_valid);
    else n_pass++;
    #7;
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (bus.rd_data !== 8'h00 || bus.rd_valid !== 1'b0)
      $display("FAIL reset_after_release: got data=%h valid=%b, want 00/0",
               bus.rd_data, bus.rd_valid);
    else n_pass++;
  endtask

  task automatic test_fill_readback();
    logic [7:0] exp_d;
    for (int n = 0; n < 32; n++) do_write(6'(n), 8'(n));
    for (int i = 0; i < 32 + LAT - 1; i++) begin
      bus.rw_en   = 1'b0;
      bus.rd_addr = 6'(i);
      tick();
      if (i >= LAT - 1) begin
        exp_d = 8'(i - (LAT - 1));
        n_checks++;
        if (bus.rd_data !== exp_d)
          $display("FAIL fill_data[%0d]: got %h, want %h", exp_d, bus.rd_data, exp_d);
        else n_pass++;
        n_checks++;
        if (bus.rd_valid !== 1'b1)
          $display("FAIL fill_valid[%0d]: got %b, want 1", exp_d, bus.rd_valid);
        else n_pass++;
      end
    end
  endtask

  task automatic test_write_hold();
    logic [7:0] d;
    logic       v;
    logic       exp_v;
    do_read(6'd5, d, v);
    n_checks++;
    if (d !== 8'h05 || v !== 1'b1)
      $display("FAIL hold_read5: got data=%h valid=%b, want 05/1", d, v);
    else n_pass++;
    for (int k = 1; k <= 3; k++) begin
      do_write(6'd40, 8'hAA);
      // With the output stage the read result still drains on the first write edge.
      exp_v = (k == 1) && (LAT == 2);
      n_checks++;
      if (bus.rd_data !== 8'h05 || bus.rd_valid !== exp_v)
        $display("FAIL hold_write%0d: got data=%h valid=%b, want 05/%b",
                 k, bus.rd_data, bus.rd_valid, exp_v);
      else n_pass++;
    end
    do_read(6'd40, d, v);
    n_checks++;
    if (d !== 8'hAA || v !== 1'b1)
      $display("FAIL hold_read40: got data=%h valid=%b, want aa/1", d, v);
    else n_pass++;
  endtask

  task automatic test_boundary();
    logic [7:0] d;
    logic       v;
    do_write(6'd0, 8'h3C);
    do_write(6'd63, 8'hC3);
    do_read(6'd63, d, v);
    n_checks++;
    if (d !== 8'hC3 || v !== 1'b1)
      $display("FAIL boundary_63: got data=%h valid=%b, want c3/1", d, v);
    else n_pass++;
    do_read(6'd0, d, v);
    n_checks++;
    if (d !== 8'h3C || v !== 1'b1)
      $display("FAIL boundary_0: got data=%h valid=%b, want 3c/1", d, v);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    logic       v;
    do_write(6'd7, 8'h77);
    do_read(6'd7, d, v);
    n_checks++;
    if (d !== 8'h77 || v !== 1'b1)
      $display("FAIL raw_first: got data=%h valid=%b, want 77/1", d, v);
    else n_pass++;
    do_write(6'd7, 8'h11);
    do_read(6'd7, d, v);
    n_checks++;
    if (d !== 8'h11 || v !== 1'b1)
      $display("FAIL raw_overwrite: got data=%h valid=%b, want 11/1", d, v);
    else n_pass++;
  endtask

  task automatic test_reset_mid_read();
    logic [7:0] d;
    logic       v;
    do_read(6'd20, d, v);
    n_checks++;
    if (d !== 8'h14 || v !== 1'b1)
      $display("FAIL midrst_pre: got data=%h valid=%b, want 14/1", d, v);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.rd_data !== 8'h00 || bus.rd_valid !== 1'b0)
      $display("FAIL midrst_immediate: got data=%h valid=%b, want 00/0",
               bus.rd_data, bus.rd_valid);
    else n_pass++;
    tick();
    n_checks++;
    if (bus.rd_data !== 8'h00 || bus.rd_valid !== 1'b0)
      $display("FAIL midrst_held: got data=%h valid=%b, want 00/0", bus.rd_data, bus.rd_valid);
    else n_pass++;
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (bus.rd_data !== 8'h00 || bus.rd_valid !== 1'b0)
      $display("FAIL midrst_release: got data=%h valid=%b, want 00/0",
               bus.rd_data, bus.rd_valid);
    else n_pass++;
    do_read(6'd10, d, v);
    n_checks++;
    if (d !== 8'h0A || v !== 1'b1)
      $display("FAIL midrst_read10: got data=%h valid=%b, want 0a/1", d, v);
    else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_fill_readback();
    test_write_hold();
    test_boundary();
    test_back_to_back();
    test_reset_mid_read();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ram_sdp_rw_core.md
Name: ram_sdp_rw_core

Overview:
- 64 x 8 simple dual-port RAM block for the on-board RAM bring-up test.
- A single mode select rw_en chooses between a write cycle and a read cycle.
- Separate write and read address buses; synchronous registered read data.
- Sits under the RAM test top level, between the test sequencer (address/data generator) and the result checker.

Parameters:
- DATA_WIDTH, 8, width of a memory word and of wr_data/rd_data.
- ADDR_WIDTH, 6, width of wr_addr/rd_addr.
- DEPTH, 64, number of words; must equal 2**ADDR_WIDTH.

Ports:
- sys_clk  input  1  single clock; all write and read activity on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- rw_en  input  1  1 = write cycle, 0 = read cycle.
- wr_addr  input  ADDR_WIDTH  write address, sampled when rw_en=1.
- wr_data  input  DATA_WIDTH  write data, sampled when rw_en=1.
- rd_addr  input  ADDR_WIDTH  read address, sampled when rw_en=0.
- rd_data  output  DATA_WIDTH  registered read data.
- rd_valid  output  1  high for one cycle when rd_data carries a new read result.

Behaviour:
- Interface: reset rst_n, asynchronous, active-low; clock sys_clk.
- Reset:
  - rd_data=0 and rd_valid=0 immediately on rst_n low; both held until the first rising edge after release.
  - Memory array is not cleared by reset.
  - Array is initialised to all zeros at configuration/simulation start.
- Write (rw_en=1 at a rising edge): mem[wr_addr] <= wr_data. During write cycles rd_data holds its last value and rd_valid=0.
- Read (rw_en=0 at a rising edge): rd_data <= mem[rd_addr] and rd_valid <= 1. Latency is 1 cycle: the address presented before edge N appears on rd_data after edge N.
- Read and write are mutually exclusive per cycle, so there is no same-cycle collision. A read in the cycle after a write to the same address returns the newly written data.
- Addresses:
  - Full ADDR_WIDTH range 0..DEPTH-1 is valid.
  - No wrap logic inside the block; address sequencing belongs to the caller.
- Reset asserted mid-operation:
  - Any in-flight read result is discarded; rd_data=0, rd_valid=0.
  - Words already written stay intact.
  - A write on the same edge as reset assertion is not guaranteed.
- Memory maps to inferred block RAM when available; otherwise a register array. Function is identical either way.
- Unknown/X on rw_en is not supported; the caller must drive 0 or 1 whenever out of reset.

Optional Feature:
- Macro: RAM_OUT_REG_EN.
- Defined: an extra output pipeline register follows the read register.
  - Read latency becomes 2 cycles; rd_valid is delayed identically.
  - The pipeline register also resets to 0 asynchronously.
  - During write cycles both stages hold, except that a pending valid result still drains.
- Not defined: 1-cycle read latency as described above.

Test Plan:
- Reset check: hold rst_n=0 for 20 ns, then release -> rd_data=0 and rd_valid=0 throughout reset and until the first read edge.
- Fill and readback:
  - Stimulus: rw_en=1, write data N to address N for N=0..31 (32 consecutive cycles); then rw_en=0, read addresses 0..31.
  - Required: rd_data=N exactly one cycle after rd_addr=N; rd_valid high on each of those 32 cycles.
- Write hold:
  - Stimulus: after a read of address 5 returns 5, write 0xAA to address 40 for 3 cycles.
  - Required: rd_data stays 5 and rd_valid=0 during the writes; a subsequent read of address 40 returns 0xAA.
- Boundary addresses:
  - Stimulus: write 0x3C to address 0 and 0xC3 to address 63, then read addresses 63 and 0.
  - Required: reads return 0xC3 then 0x3C; no aliasing between the two addresses.
- Reset mid-read:
  - Stimulus: during a read sweep, pulse rst_n low for 1 cycle.
  - Required: rd_data forced to 0 immediately; after release, reading address 10 returns the previously written value 10.
- RAM_OUT_REG_EN build: repeat the fill-and-readback scenario -> rd_data=N appears two cycles after rd_addr=N, with rd_valid aligned to it.
